// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: splits 0..31-bit SLL/SRL/SRA requests into passes
// of at most 15 bits through an external zero-fill left barrel shifter.
module shift_seq_ctrl #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned AMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [1:0]         i_op,
    input  logic [31:0]        i_data,
    input  logic [AMT_W-1:0]   i_amt,
    output logic [31:0]        o_sh_b,
    output logic [SEL_W-1:0]   o_sh_sel,
    input  logic [31:0]        i_sh_bsl,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [31:0]        o_result,
    output logic               o_err,
    output logic               o_busy
);

    localparam int unsigned    DATA_W   = 32;
    localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'((1 << SEL_W) - 1);
    localparam logic [1:0]     OP_SRL   = 2'b01;
    localparam logic [1:0]     OP_SRA   = 2'b10;
    localparam logic [1:0]     OP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_work;
    logic [DATA_W-1:0]   w_work_nxt;
    logic [AMT_W-1:0]    r_rem;
    logic [AMT_W-1:0]    w_rem_nxt;
    logic                r_inv;
    logic                w_inv_nxt;
    logic                r_rev;
    logic                w_rev_nxt;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   w_result_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic                w_accept;
    logic                w_acc_inv;
    logic                w_acc_rev;
    logic [DATA_W-1:0]   w_acc_pre;
    logic [AMT_W-1:0]    w_step;
    logic [AMT_W-1:0]    w_rem_left;
    logic [DATA_W-1:0]   w_bsl_rev;

    function automatic logic [DATA_W-1:0] f_bitrev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        for (int i = 0; i < int'(DATA_W); i++) begin
            y[i] = x[DATA_W-1-i];
        end
        return y;
    endfunction

    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_rsp_valid = (r_state == ST_DONE);
    assign o_result    = r_result;
    assign o_err       = r_err;

    // Right shifts: reverse, left-shift, reverse back; SRA wraps that in inversion
    // so the zero fill becomes sign fill.
    assign w_accept   = i_req_valid && o_req_ready;
    assign w_acc_inv  = (i_op == OP_SRA) && i_data[DATA_W-1];
    assign w_acc_rev  = (i_op == OP_SRL) || (i_op == OP_SRA);
    assign w_acc_pre  = w_acc_inv ? ~i_data : i_data;
    assign w_step     = (r_rem > MAX_STEP) ? MAX_STEP : r_rem;
    assign w_rem_left = r_rem - w_step;
    assign w_bsl_rev  = f_bitrev(i_sh_bsl);

    // Shifter inputs are forced quiet outside PASS.
    assign o_sh_b   = (r_state == ST_PASS) ? r_work : '0;
    assign o_sh_sel = (r_state == ST_PASS) ? SEL_W'(w_step) : '0;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_rem_nxt    = r_rem;
        w_inv_nxt    = r_inv;
        w_rev_nxt    = r_rev;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_inv_nxt  = w_acc_inv;
                    w_rev_nxt  = w_acc_rev;
                    w_work_nxt = w_acc_rev ? f_bitrev(w_acc_pre) : i_data;
                    w_rem_nxt  = i_amt;
                    if (i_op == OP_ILL) begin
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = i_data;
                        w_err_nxt    = 1'b1;
                    end else if (i_amt == '0) begin
                        // Zero shift: the round trip through reversal is identity.
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = i_data;
                        w_err_nxt    = 1'b0;
                    end else begin
                        w_state_nxt  = ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                w_work_nxt = i_sh_bsl;
                w_rem_nxt  = w_rem_left;
                if (w_rem_left == '0) begin
                    w_state_nxt  = ST_DONE;
                    w_err_nxt    = 1'b0;
                    if (r_rev) begin
                        w_result_nxt = r_inv ? ~w_bsl_rev : w_bsl_rev;
                    end else begin
                        w_result_nxt = i_sh_bsl;
                    end
                end
            end
            ST_DONE: begin
                if (i_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_work   <= '0;
            r_rem    <= '0;
            r_inv    <= 1'b0;
            r_rev    <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_work   <= w_work_nxt;
            r_rem    <= w_rem_nxt;
            r_inv    <= w_inv_nxt;
            r_rev    <= w_rev_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a behavioural zero-fill left shifter
// closing the loop on o_sh_b/o_sh_sel.
module tb_shift_seq_ctrl;

    logic        clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_op;
    logic [31:0] i_data;
    logic [4:0]  i_amt;
    logic [31:0] o_sh_b;
    logic [3:0]  o_sh_sel;
    logic [31:0] i_sh_bsl;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_result;
    logic        o_err;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] sb_q[$];

    shift_seq_ctrl #(.SEL_W(4), .AMT_W(5)) u_dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_op        (i_op),
        .i_data      (i_data),
        .i_amt       (i_amt),
        .o_sh_b      (o_sh_b),
        .o_sh_sel    (o_sh_sel),
        .i_sh_bsl    (i_sh_bsl),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_result    (o_result),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    assign i_sh_bsl = o_sh_b << o_sh_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_model(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] a);
        case (op)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return 32'($signed(d) >>> a);
            default: return d;
        endcase
    endfunction

    // One request: checks per-pass select, exact latency, optional response stall.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] data,
                           input logic [4:0] amt, input int stall);
        int          passes;
        logic [4:0]  rem;
        logic [4:0]  step;
        logic [32:0] exp;
        passes = (op == 2'b11 || amt == 5'd0) ? 0 : (int'(amt) + 14) / 15;
        chk("req_ready_pre", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_op        = op;
        i_data      = data;
        i_amt       = amt;
        sb_q.push_back({(op == 2'b11), f_model(op, data, amt)});
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_data      = $urandom;
        i_amt       = 5'($urandom);
        i_op        = 2'($urandom);
        rem = amt;
        for (int p = 0; p < passes; p++) begin
            step = (rem > 5'd15) ? 5'd15 : rem;
            chk("pass_sel", 32'(o_sh_sel), 32'(step));
            chk("pass_busy", 32'(o_busy), 32'd1);
            chk("pass_no_valid", 32'(o_rsp_valid), 32'd0);
            rem = rem - step;
            @(posedge clk); #1;
        end
        chk("rsp_latency", 32'(o_rsp_valid), 32'd1);
        chk("done_sel_quiet", 32'(o_sh_sel), 32'd0);
        exp = (sb_q.size() > 0) ? sb_q[0] : 33'd0;
        for (int s = 0; s < stall; s++) begin
            i_req_valid = 1'b1;
            i_data      = $urandom;
            chk("stall_result", o_result, exp[31:0]);
            chk("stall_req_ready", 32'(o_req_ready), 32'd0);
            chk("stall_busy", 32'(o_busy), 32'd1);
            chk("stall_valid", 32'(o_rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        chk("result", o_result, exp[31:0]);
        chk("err", 32'(o_err), 32'(exp[32]));
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        chk("idle_req_ready", 32'(o_req_ready), 32'd1);
        chk("idle_valid", 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_op        = 2'b00;
        i_data      = 32'd0;
        i_amt       = 5'd0;
        i_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_sh_b", o_sh_b, 32'd0);
        chk("rst_sh_sel", 32'(o_sh_sel), 32'd0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        run_txn(2'b00, 32'h0000_0001, 5'd4,  0);
        run_txn(2'b00, 32'h0000_0001, 5'd31, 0);
        run_txn(2'b00, 32'h0000_0001, 5'd16, 0);
        run_txn(2'b00, 32'h0000_0001, 5'd15, 0);
        run_txn(2'b00, 32'h0000_0001, 5'd30, 0);
        run_txn(2'b01, 32'h8000_0000, 5'd31, 0);
        run_txn(2'b10, 32'h8000_0000, 5'd31, 0);
        run_txn(2'b10, 32'h7000_0000, 5'd4,  0);
        run_txn(2'b10, 32'hF000_0000, 5'd4,  0);
        run_txn(2'b00, 32'hDEAD_BEEF, 5'd0,  0);
        run_txn(2'b11, 32'h1234_5678, 5'd7,  0);
        run_txn(2'b10, 32'hC3A5_0F96, 5'd17, 3);
        for (int k = 0; k < 8; k++) begin
            run_txn(2'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset mid-flight during the second pass of an amt=31 shift.
        i_req_valid = 1'b1;
        i_op        = 2'b00;
        i_data      = 32'h0000_0001;
        i_amt       = 5'd31;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("second_pass_sel", 32'(o_sh_sel), 32'd15);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_sh_sel", 32'(o_sh_sel), 32'd0);
        chk("arst_sh_b", o_sh_b, 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_req_ready", 32'(o_req_ready), 32'd0);
        chk("arst_valid", 32'(o_rsp_valid), 32'd0);
        chk("arst_result", o_result, 32'd0);
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_txn(2'b00, 32'h0000_0003, 5'd1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
